// File: rtl/rr_switch_alloc_pkg.sv
// Shared types and constants for the per-router round-robin switch allocator.
package rr_switch_alloc_pkg;

  localparam int unsigned NUM_PORTS = 5;
  localparam int unsigned BITS_DIR  = 3;

  typedef enum logic [BITS_DIR-1:0] {
    NORTH = 3'd0,
    EAST  = 3'd1,
    SOUTH = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } dir_e;

  typedef enum logic [1:0] {
    SA_IDLE = 2'd0,
    SA_WAIT = 2'd1,
    SA_BUSY = 2'd2
  } sa_state_e;

  localparam logic [BITS_DIR-1:0] SA_ILLEGAL_DIR_MIN = 3'd5;

  // Port index `step` positions after `base`, wrapping over the five ports.
  function automatic logic [BITS_DIR-1:0] rr_next(input logic [BITS_DIR-1:0] base,
                                                  input int unsigned         step);
    int unsigned s;
    s = (32'(base) + step) % NUM_PORTS;
    return s[BITS_DIR-1:0];
  endfunction

endpackage

// File: rtl/rr_switch_alloc_arb.sv
// Combinational 5-way round-robin arbiter: search starts at ptr+1 (mod 5).
module rr_arbiter5
  import rr_switch_alloc_pkg::*;
(
  input  logic [NUM_PORTS-1:0] req,
  input  logic [BITS_DIR-1:0]  ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [BITS_DIR-1:0]  idx,
  output logic                 valid
);

  logic [BITS_DIR-1:0] cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    cand  = '0;
    for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
      cand = rr_next(ptr, k);
      if (!valid && req[cand]) begin
        valid     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = cand;
      end
    end
  end

endmodule

// File: rtl/rr_switch_alloc.sv
// Switch allocator: one round-robin arbiter and IDLE/WAIT/BUSY FSM per output,
// granting FIFO heads to tx serializers and discarding flits with illegal directions.
module rr_switch_alloc
  import rr_switch_alloc_pkg::*;
#(
  parameter int          routerid = -1,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  in_empty,
  input  logic [14:0] in_dir,
  output logic [4:0]  in_read,
  output logic [4:0]  out_ena,
  input  logic [4:0]  out_busy,
  output logic [14:0] out_sel,
  output logic        drop,
  output logic [4:0]  timeout
);

  if (TIMEOUT == 0 || TIMEOUT > 15) begin : g_bad_timeout
    $error("rr_switch_alloc: TIMEOUT must be in 1..15");
  end
  if (routerid < -1) begin : g_bad_routerid
    $error("rr_switch_alloc: routerid must be >= -1");
  end

  localparam logic [3:0] TMO = 4'(TIMEOUT);

  sa_state_e            state_q [NUM_PORTS];
  sa_state_e            state_d [NUM_PORTS];
  logic [3:0]           cnt_q   [NUM_PORTS];
  logic [3:0]           cnt_d   [NUM_PORTS];
  logic [BITS_DIR-1:0]  sel_q   [NUM_PORTS];
  logic [BITS_DIR-1:0]  sel_d   [NUM_PORTS];
  logic [BITS_DIR-1:0]  ptr_q   [NUM_PORTS];
  logic [BITS_DIR-1:0]  ptr_d   [NUM_PORTS];
  logic [NUM_PORTS-1:0] req     [NUM_PORTS];
  logic [NUM_PORTS-1:0] gnt     [NUM_PORTS];
  logic [BITS_DIR-1:0]  win     [NUM_PORTS];
  logic [NUM_PORTS-1:0] any;
  logic [NUM_PORTS-1:0] locked;
  logic [NUM_PORTS-1:0] illegal;
  logic [NUM_PORTS-1:0] drop_oh;

  // An input is locked while any output that granted it is outside IDLE.
  always_comb begin
    locked = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      if (state_q[o] != SA_IDLE) locked[sel_q[o]] = 1'b1;
    end
  end

  always_comb begin
    logic [BITS_DIR-1:0] head;
    logic                live;
    head    = '0;
    live    = 1'b0;
    illegal = '0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) req[o] = '0;
    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
      head       = in_dir[BITS_DIR*i +: BITS_DIR];
      live       = !in_empty[i] && !locked[i];
      illegal[i] = live && (head >= SA_ILLEGAL_DIR_MIN);
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        req[o][i] = live && (head == BITS_DIR'(o));
      end
    end
    drop_oh = illegal & (~illegal + 5'd1);
  end

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter5 u_arb (
      .req   (req[o]),
      .ptr   (ptr_q[o]),
      .gnt   (gnt[o]),
      .idx   (win[o]),
      .valid (any[o])
    );
    assign out_sel[BITS_DIR*o +: BITS_DIR] = sel_q[o];
  end

  always_comb begin
    in_read = '0;
    out_ena = '0;
    timeout = '0;
    drop    = 1'b0;
    for (int unsigned o = 0; o < NUM_PORTS; o++) begin
      state_d[o] = state_q[o];
      cnt_d[o]   = cnt_q[o];
      sel_d[o]   = sel_q[o];
      ptr_d[o]   = ptr_q[o];
      unique case (state_q[o])
        SA_IDLE: begin
          cnt_d[o] = '0;
          if (!out_busy[o] && any[o]) begin
            out_ena[o] = 1'b1;
            in_read    = in_read | gnt[o];
            sel_d[o]   = win[o];
            ptr_d[o]   = win[o];
            cnt_d[o]   = 4'd1;
            state_d[o] = SA_WAIT;
          end
        end
        SA_WAIT: begin
          if (out_busy[o]) begin
            state_d[o] = SA_BUSY;
          end else if (cnt_q[o] >= TMO) begin
            timeout[o] = 1'b1;
            state_d[o] = SA_IDLE;
          end else begin
            cnt_d[o] = cnt_q[o] + 4'd1;
          end
        end
        SA_BUSY: begin
          if (!out_busy[o]) state_d[o] = SA_IDLE;
        end
        default: state_d[o] = SA_IDLE;
      endcase
    end
    in_read = in_read | drop_oh;
    drop    = |drop_oh;
    // Pulses are decoded from live inputs, so hold them low while reset is asserted.
    if (!reset) begin
      in_read = '0;
      out_ena = '0;
      timeout = '0;
      drop    = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= SA_IDLE;
        cnt_q[o]   <= '0;
        sel_q[o]   <= '0;
        ptr_q[o]   <= LOCAL;
      end
    end else begin
      for (int unsigned o = 0; o < NUM_PORTS; o++) begin
        state_q[o] <= state_d[o];
        cnt_q[o]   <= cnt_d[o];
        sel_q[o]   <= sel_d[o];
        ptr_q[o]   <= ptr_d[o];
      end
    end
  end

endmodule
